mov_register_file: RTL and testbench

Parametrised multi-entry register file: the successor to the single MOV register. Holds DEPTH words of WIDTH bits with one external write port, two combinational read ports, and an internal register-to-register MOV engine gated by a pending-write scoreboard. Sits between decode (issue/MOV requests) and the ALU/load writeback path. A synchronous `flush` wipes data, scoreboard and the in-flight MOV on a mispredict/mismatch.

---
 rtl/mov_pkg.sv | 29 ++
 rtl/mov_scoreboard.sv | 67 ++++++
 rtl/mov_register_file.sv | 161 ++++++++++++++++
 tb/tb_mov_register_file.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mov_pkg.sv
// mov_pkg: shared defaults, MOV engine state type, MOV request struct and the
// address-validity mask helper used by mov_register_file.
package mov_pkg;

   localparam int unsigned MOV_WIDTH_DEF = 8;
   localparam int unsigned MOV_DEPTH_DEF = 8;
   localparam int unsigned MOV_AW_MAX    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mov_state_e;

   typedef struct packed {
      logic [MOV_AW_MAX-1:0] src;
      logic [MOV_AW_MAX-1:0] dst;
   } mov_req_t;

   // Bit i set when address i names a real register (i < depth).
   function automatic logic [255:0] mov_addr_mask(input int unsigned depth);
      logic [255:0] m;
      m = '0;
      for (int unsigned i = 0; i < 256; i++) begin
         m[i] = (i < depth);
      end
      return m;
   endfunction

endpackage

// File: rtl/mov_scoreboard.sv
// mov_scoreboard: pending-write bits for every register. Two set ports
// (issue, MOV accept) and two clear ports (writeback, MOV commit); a set
// always beats a clear on the same bit. Flush wipes everything.
// Storage covers the full 2**AW address space; the owner never sets bits
// for out-of-range addresses, so those taps always read 0.
module mov_scoreboard
   import mov_pkg::*;
#(
   parameter  int unsigned DEPTH = MOV_DEPTH_DEF,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_flush,
   input  logic          i_set0_en,
   input  logic [AW-1:0] i_set0_addr,
   input  logic          i_set1_en,
   input  logic [AW-1:0] i_set1_addr,
   input  logic          i_clr0_en,
   input  logic [AW-1:0] i_clr0_addr,
   input  logic          i_clr1_en,
   input  logic [AW-1:0] i_clr1_addr,
   input  logic [AW-1:0] i_tap_a_addr,
   input  logic [AW-1:0] i_tap_b_addr,
   input  logic [AW-1:0] i_tap_src_addr,
   input  logic [AW-1:0] i_tap_dst_addr,
   output logic          o_tap_a,
   output logic          o_tap_b,
   output logic          o_tap_src,
   output logic          o_tap_dst
);

   localparam int unsigned NSLOT = 1 << AW;

   logic [NSLOT-1:0] r_pend;
   logic [NSLOT-1:0] w_set;
   logic [NSLOT-1:0] w_clr;
   logic [NSLOT-1:0] w_pend_nxt;

   // Decode set/clear strobes; sets applied after clears so set wins.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_set0_en) w_set[i_set0_addr] = 1'b1;
      if (i_set1_en) w_set[i_set1_addr] = 1'b1;
      if (i_clr0_en) w_clr[i_clr0_addr] = 1'b1;
      if (i_clr1_en) w_clr[i_clr1_addr] = 1'b1;
      w_pend_nxt = (r_pend & ~w_clr) | w_set;
   end

   // Pending-bit register with async reset and synchronous flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else if (i_flush) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   assign o_tap_a   = r_pend[i_tap_a_addr];
   assign o_tap_b   = r_pend[i_tap_b_addr];
   assign o_tap_src = r_pend[i_tap_src_addr];
   assign o_tap_dst = r_pend[i_tap_dst_addr];

endmodule

// File: rtl/mov_register_file.sv
// mov_register_file: DEPTH x WIDTH register file with one writeback port,
// two combinational read ports and a two-state register-to-register MOV
// engine gated by the pending-write scoreboard.
// Optional feature: define MOV_RF_BYPASS_EN to forward same-cycle writeback
// data (and a cleared pend bit) onto matching read ports.
module mov_register_file
   import mov_pkg::*;
#(
   parameter  int unsigned WIDTH = MOV_WIDTH_DEF,
   parameter  int unsigned DEPTH = MOV_DEPTH_DEF,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   input  logic             mov_valid,
   input  logic [AW-1:0]    mov_src,
   input  logic [AW-1:0]    mov_dst,
   output logic             mov_ready,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_pend_a,
   output logic             rd_pend_b
);

   localparam int unsigned      NSLOT = 1 << AW;
   localparam logic [NSLOT-1:0] VALID = NSLOT'(mov_addr_mask(DEPTH));

   logic [WIDTH-1:0] r_regs [NSLOT];
   mov_state_e       r_state;
   mov_state_e       w_state_nxt;
   logic [AW-1:0]    r_mv_dst;
   logic [WIDTH-1:0] r_mv_data;

   logic             w_wr_ok;
   logic             w_iss_ok;
   logic             w_accept;
   logic             w_commit;
   logic             w_pend_a;
   logic             w_pend_b;
   logic             w_pend_src;
   logic             w_pend_dst;

   // Writes/issues to out-of-range addresses and anything during flush are dropped.
   assign w_wr_ok  = wr_en  && VALID[wr_addr]  && !flush;
   assign w_iss_ok = iss_en && VALID[iss_addr] && !flush;

   assign mov_ready = (r_state == IDLE) && VALID[mov_src] && VALID[mov_dst]
                      && !w_pend_src && !w_pend_dst;

   mov_scoreboard #(
      .DEPTH (DEPTH)
   ) u_sb (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_flush        (flush),
      .i_set0_en      (w_iss_ok),
      .i_set0_addr    (iss_addr),
      .i_set1_en      (w_accept),
      .i_set1_addr    (mov_dst),
      .i_clr0_en      (w_wr_ok),
      .i_clr0_addr    (wr_addr),
      .i_clr1_en      (w_commit),
      .i_clr1_addr    (r_mv_dst),
      .i_tap_a_addr   (rd_addr_a),
      .i_tap_b_addr   (rd_addr_b),
      .i_tap_src_addr (mov_src),
      .i_tap_dst_addr (mov_dst),
      .o_tap_a        (w_pend_a),
      .o_tap_b        (w_pend_b),
      .o_tap_src      (w_pend_src),
      .o_tap_dst      (w_pend_dst)
   );

   // MOV engine state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // MOV engine next state: accept in IDLE, commit (unless overwritten by writeback) in BUSY.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (mov_valid && mov_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            w_commit    = !(w_wr_ok && (wr_addr == r_mv_dst));
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (flush) begin
         w_accept    = 1'b0;
         w_commit    = 1'b0;
         w_state_nxt = IDLE;
      end
   end

   // Capture source data and destination when a MOV is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mv_dst  <= '0;
         r_mv_data <= '0;
      end else if (w_accept) begin
         r_mv_dst  <= mov_dst;
         r_mv_data <= r_regs[mov_src];
      end
   end

   // Register array: flush clears, writeback is applied after commit so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NSLOT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < NSLOT; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_commit) r_regs[r_mv_dst] <= r_mv_data;
         if (w_wr_ok)  r_regs[wr_addr]  <= wr_data;
      end
   end

   // Combinational read ports, with optional same-cycle writeback forwarding.
   always_comb begin
      rd_data_a = VALID[rd_addr_a] ? r_regs[rd_addr_a] : '0;
      rd_data_b = VALID[rd_addr_b] ? r_regs[rd_addr_b] : '0;
      rd_pend_a = w_pend_a;
      rd_pend_b = w_pend_b;
`ifdef MOV_RF_BYPASS_EN
      if (w_wr_ok && (rd_addr_a == wr_addr)) begin
         rd_data_a = wr_data;
         rd_pend_a = 1'b0;
      end
      if (w_wr_ok && (rd_addr_b == wr_addr)) begin
         rd_data_b = wr_data;
         rd_pend_b = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_mov_register_file.sv
// tb_mov_register_file: directed scenarios followed by random traffic, all
// checked against a behavioural model of the register file (DEPTH=6 so the
// out-of-range addresses 6 and 7 are exercised).
module tb_mov_register_file;
   import mov_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned D = 6;
   localparam int unsigned A = 3;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         flush     = 1'b0;
   logic         wr_en     = 1'b0;
   logic [A-1:0] wr_addr   = '0;
   logic [W-1:0] wr_data   = '0;
   logic         iss_en    = 1'b0;
   logic [A-1:0] iss_addr  = '0;
   logic         mov_valid = 1'b0;
   logic [A-1:0] mov_src   = '0;
   logic [A-1:0] mov_dst   = '0;
   logic [A-1:0] rd_addr_a = '0;
   logic [A-1:0] rd_addr_b = '0;
   logic         mov_ready;
   logic [W-1:0] rd_data_a;
   logic [W-1:0] rd_data_b;
   logic         rd_pend_a;
   logic         rd_pend_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [W-1:0] m_regs [8];
   bit           m_pend [8];
   bit           m_busy;
   int unsigned  m_dst;
   logic [W-1:0] m_data;

   mov_register_file #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .mov_valid (mov_valid),
      .mov_src   (mov_src),
      .mov_dst   (mov_dst),
      .mov_ready (mov_ready),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_pend_a (rd_pend_a),
      .rd_pend_b (rd_pend_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_dst  = 0;
      m_data = '0;
   endtask

   function automatic bit wr_fwd(input int unsigned a);
`ifdef MOV_RF_BYPASS_EN
      return wr_en && !flush && (32'(wr_addr) == a) && (a < D);
`else
      return (a > 1000);
`endif
   endfunction

   function automatic logic [W-1:0] e_data(input int unsigned a);
      if (a >= D)   return '0;
      if (wr_fwd(a)) return wr_data;
      return m_regs[a];
   endfunction

   function automatic bit e_pend(input int unsigned a);
      if (a >= D)   return 1'b0;
      if (wr_fwd(a)) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic bit e_ready();
      int unsigned s;
      int unsigned d;
      s = 32'(mov_src);
      d = 32'(mov_dst);
      return !m_busy && (s < D) && (d < D) && !m_pend[s] && !m_pend[d];
   endfunction

   // Apply one clock edge's worth of architectural rules to the model.
   task automatic model_clock(input bit rdy);
      int unsigned  wa;
      int unsigned  ia;
      int unsigned  sa;
      int unsigned  da;
      logic [W-1:0] src_val;
      wa = 32'(wr_addr);
      ia = 32'(iss_addr);
      sa = 32'(mov_src);
      da = 32'(mov_dst);
      if (flush) begin
         model_reset();
      end else begin
         src_val = m_regs[sa];
         if (m_busy) begin
            if (!(wr_en && wa < D && wa == m_dst)) begin
               m_regs[m_dst] = m_data;
               m_pend[m_dst] = 1'b0;
            end
            m_busy = 1'b0;
         end
         if (wr_en && wa < D) begin
            m_regs[wa] = wr_data;
            m_pend[wa] = 1'b0;
         end
         if (mov_valid && rdy) begin
            m_data   = src_val;
            m_dst    = da;
            m_pend[da] = 1'b1;
            m_busy   = 1'b1;
         end
         if (iss_en && ia < D) m_pend[ia] = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".rd_data_a"}, rd_data_a, e_data(32'(rd_addr_a)));
      chk({tag, ".rd_data_b"}, rd_data_b, e_data(32'(rd_addr_b)));
      chk({tag, ".rd_pend_a"}, rd_pend_a, e_pend(32'(rd_addr_a)));
      chk({tag, ".rd_pend_b"}, rd_pend_b, e_pend(32'(rd_addr_b)));
      chk({tag, ".mov_ready"}, mov_ready, e_ready());
   endtask

   // Check current cycle, clock once, advance the model; ends at posedge+1.
   task automatic step(input string tag);
      bit rdy;
      #2;
      check_outputs(tag);
      rdy = e_ready();
      @(posedge clk);
      model_clock(rdy);
      #1;
   endtask

   initial begin
      mov_req_t rq;
      model_reset();

      // Reset held: outputs at reset values
      #3;
      chk("in_reset.mov_ready", mov_ready, 1);
      chk("in_reset.rd_data_a", rd_data_a, 0);
      #9;
      rst_n = 1'b1;

      // Read every address after reset (6 and 7 are out of range)
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i);
         rd_addr_b = 3'(7 - i);
         step("rst_read");
      end
      chk("rst.mov_ready_const", mov_ready, 1);

      // Write addr 3 = 0xA5
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3;
      #1;
`ifdef MOV_RF_BYPASS_EN
      chk("wr3.same_cycle", rd_data_a, 8'hA5);
`else
      chk("wr3.same_cycle", rd_data_a, 8'h00);
`endif
      step("wr3");
      wr_en = 1'b0;
      #1;
      chk("wr3.next_cycle", rd_data_a, 8'hA5);

      // Issue reg 2, MOV 2->5 blocked until writeback of reg 2
      iss_en = 1'b1; iss_addr = 3'd2;
      step("iss2");
      iss_en = 1'b0;
      mov_valid = 1'b1; mov_src = 3'd2; mov_dst = 3'd5; rd_addr_a = 3'd2; rd_addr_b = 3'd5;
      #1;
      chk("mov25.blocked", mov_ready, 0);
      chk("mov25.src_pend", rd_pend_a, 1);
      step("mov25_wait0");
      step("mov25_wait1");
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C;
      #1;
      chk("mov25.blocked_wr", mov_ready, 0);
      step("wr2");
      wr_en = 1'b0;
      #1;
      chk("mov25.ready", mov_ready, 1);
      step("mov25_acc");
      mov_valid = 1'b0;
      #1;
      chk("mov25.busy_pend5", rd_pend_b, 1);
      chk("mov25.busy_ready", mov_ready, 0);
      chk("mov25.busy_data5", rd_data_b, 8'h00);
      step("mov25_commit");
      chk("mov25.data5", rd_data_b, 8'h3C);
      chk("mov25.pend5_clear", rd_pend_b, 0);

      // MOV 1->4 overridden by writeback to 4 on the commit edge
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11;
      step("wr1");
      wr_en = 1'b0;
      mov_valid = 1'b1; mov_src = 3'd1; mov_dst = 3'd4; rd_addr_a = 3'd4;
      step("mov14_acc");
      mov_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
      step("wr4_busy");
      wr_en = 1'b0;
      #1;
      chk("mov14.data4", rd_data_a, 8'h77);
      chk("mov14.pend4", rd_pend_a, 0);

      // Flush during BUSY
      mov_valid = 1'b1; mov_src = 3'd3; mov_dst = 3'd0; rd_addr_a = 3'd0; rd_addr_b = 3'd3;
      step("mov30_acc");
      mov_valid = 1'b0; flush = 1'b1;
      #1;
      chk("flush.busy_pend0", rd_pend_a, 1);
      step("flush");
      flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i);
         #1;
         chk("flush.data", rd_data_a, 0);
         chk("flush.pend", rd_pend_a, 0);
      end
      chk("flush.ready", mov_ready, 1);
      step("post_flush");

      // Async reset mid-MOV
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
      step("wr2b");
      wr_en = 1'b0;
      mov_valid = 1'b1; mov_src = 3'd2; mov_dst = 3'd1; rd_addr_a = 3'd1;
      step("mov21_acc");
      mov_valid = 1'b0;
      #1;
      chk("arst.busy_pend1", rd_pend_a, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst.data1", rd_data_a, 0);
      chk("arst.pend1", rd_pend_a, 0);
      chk("arst.ready", mov_ready, 1);
      model_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      model_clock(e_ready());
      #1;
      chk("arst.no_commit", rd_data_a, 0);
      step("post_arst");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         flush     = ($urandom_range(0, 39) == 0);
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_addr   = 3'($urandom_range(0, 7));
         wr_data   = 8'($urandom);
         iss_en    = ($urandom_range(0, 3) == 0);
         iss_addr  = 3'($urandom_range(0, 7));
         mov_valid = ($urandom_range(0, 1) == 1);
         rq.src    = 8'($urandom_range(0, 7));
         rq.dst    = 8'($urandom_range(0, 7));
         mov_src   = rq.src[A-1:0];
         mov_dst   = rq.dst[A-1:0];
         rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
         rd_addr_b = ($urandom_range(0, 3) == 0) ? mov_dst : 3'($urandom_range(0, 7));
         step("rnd");
      end
      flush = 1'b0; wr_en = 1'b0; iss_en = 1'b0; mov_valid = 1'b0;
      step("rnd_tail");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
